icache_fill: RTL and testbench

- Direct-mapped instruction cache with a line-fill state machine.
- Sits between the CPU fetch stage (pc / instruction fetch) and a multi-cycle, word-wide unified memory.
- Returns the instruction in the same cycle on a hit.
- On a miss it holds the fetch stage, fetches the full 4-word line from memory, installs it, then serves the access.
- Keeps saturating hit/miss counters for performance debug.

---
 rtl/icache_fill.sv | 156 +++++++++++++++
 tb/tb_icache_fill.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with a line-fill state machine.
// A hit returns the instruction in the same cycle. A miss stalls the fetch
// stage while the 4-word line is read from memory in order (words 0..3).
// The line is then installed and the held access is looked up again.
// Saturating hit/miss counters are provided for performance debug.
module icache_fill #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_addr,
    input  logic        if_re,
    output logic [15:0] if_instr,
    output logic        if_ready,
    input  logic        flush,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_rdy,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int LINES     = 2 ** INDEX_BITS;
    localparam int TAG_BITS  = 16 - 2 - INDEX_BITS;
    localparam int LINE_BITS = 16 - 2;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t state_q, state_d;

    // Lookup fields of the current fetch address
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [INDEX_BITS-1:0] lookup_index;
    logic [1:0]            lookup_offset;

    // Cache storage
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [15:0]           data_q [LINES][LINE_WORDS];

    // In-flight fill
    logic [LINE_BITS-1:0]  fill_line_q;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [1:0]            wcnt_q;
    logic                  flush_pend_q;

    logic lookup_hit;
    logic access_hit;
    logic access_miss;
    logic word_accept;
    logic last_word;

    assign lookup_tag    = if_addr[15:2+INDEX_BITS];
    assign lookup_index  = if_addr[1+INDEX_BITS:2];
    assign lookup_offset = if_addr[1:0];

    assign fill_index = fill_line_q[INDEX_BITS-1:0];
    assign fill_tag   = fill_line_q[LINE_BITS-1:INDEX_BITS];

    assign lookup_hit  = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
    assign access_hit  = (state_q == IDLE) && if_re && lookup_hit;
    assign access_miss = (state_q == IDLE) && if_re && !lookup_hit;
    assign word_accept = (state_q == FILL) && mem_rdy;
    assign last_word   = (wcnt_q == 2'(LINE_WORDS - 1));

    // The fetch side is served combinationally. The instruction is zero unless this is a hit.
    assign if_ready = (state_q == IDLE) && (!if_re || lookup_hit);
    assign if_instr = access_hit ? data_q[lookup_index][lookup_offset] : 16'h0000;

    // State register; reset returns to IDLE at once, dropping mem_re asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and memory request outputs
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch
        state_d  = state_q;
        mem_re   = 1'b0;
        mem_addr = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (access_miss) state_d = FILL;
            end
            FILL: begin
                mem_re   = 1'b1;
                mem_addr = {fill_line_q, wcnt_q};
                if (mem_rdy && last_word) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fill bookkeeping: latched line address, word counter, pending-flush flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line_q  <= '0;
            wcnt_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (access_miss) begin
                fill_line_q <= if_addr[15:2];
                wcnt_q      <= '0;
            end else if (word_accept) begin
                wcnt_q <= wcnt_q + 2'd1;
            end

            if (state_q == DONE)
                flush_pend_q <= 1'b0;
            else if (flush && (state_q == FILL))
                flush_pend_q <= 1'b1;
        end
    end

    // Valid bits: flush clears all lines and overrides the DONE install
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (flush)
            valid_q <= '0;
        else if (state_q == DONE)
            valid_q[fill_index] <= !flush_pend_q;
    end

    // Tag and data arrays written by the fill engine
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; valid_q alone decides whether a line can hit
        if (word_accept)
            data_q[fill_index][wcnt_q] <= mem_rd_data;
        if (state_q == DONE)
            tag_q[fill_index] <= fill_tag;
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (access_hit && (hit_cnt != 16'hFFFF))
                hit_cnt <= hit_cnt + 16'd1;
            if (access_miss && (miss_cnt != 16'hFFFF))
                miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_icache_fill.sv
// Scoreboard bench for icache_fill. The driver pushes the expected instruction
// and the expected number of stall cycles for each fetch. A monitor pops and
// compares these when the fetch is served. A memory model with a per-fill
// latency checks that requests are held stable and come out in line order.
module tb_icache_fill;
    localparam int INDEX_BITS = 6;
    localparam int LINES      = 2 ** INDEX_BITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] if_addr = 16'h0000;
    logic        if_re = 1'b0;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        flush = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rd_data;
    logic        mem_rdy;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    icache_fill #(.INDEX_BITS(INDEX_BITS), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_addr(if_addr), .if_re(if_re), .if_instr(if_instr), .if_ready(if_ready),
        .flush(flush),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rd_data(mem_rd_data), .mem_rdy(mem_rdy),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- backing memory and latency model ----------------
    logic [15:0] mem [65536];
    int          lat = 1;
    int          wait_cnt = 0;
    int          word_k = 0;
    int          words_accepted = 0;
    logic [15:0] fill_base_seen = 16'h0000;
    logic [15:0] prev_addr = 16'h0000;
    bit          prev_wait = 1'b0;

    assign mem_rdy     = mem_re && (wait_cnt == lat - 1);
    assign mem_rd_data = mem[mem_addr];

    // Memory side: count wait cycles and words accepted for the current fill
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            word_k   <= 0;
        end else if (mem_re && mem_rdy) begin
            wait_cnt       <= 0;
            word_k         <= (word_k + 1) % 4;
            words_accepted <= words_accepted + 1;
            if (word_k == 0) fill_base_seen <= mem_addr;
        end else if (mem_re) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // Memory protocol checker: request held until accepted, words in line order
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                check("mem_re_held", mem_re, 1);
                check("mem_addr_held", mem_addr, prev_addr);
            end
            if (mem_re && mem_rdy) begin
                if (word_k == 0) check("fill_first_word_offset", mem_addr[1:0], 0);
                else             check("fill_word_order", mem_addr, fill_base_seen + word_k);
            end
            prev_wait <= mem_re && !mem_rdy;
            prev_addr <= mem_addr;
        end
    end

    // ---------------- reference model: which line sits in each index ----------------
    int m_line [LINES];
    int m_hits = 0;
    int m_misses = 0;

    function automatic bit m_hit(input logic [15:0] a);
        int line;
        line = a >> 2;
        return m_line[line % LINES] == line;
    endfunction

    function automatic void m_install(input logic [15:0] a);
        int line;
        line = a >> 2;
        m_line[line % LINES] = line;
    endfunction

    function automatic void m_flush();
        foreach (m_line[i]) m_line[i] = -1;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] data;
        int          stalls;
    } exp_t;

    exp_t sb_q[$];
    int   stalls = 0;

    // Monitor: count stall cycles, compare on each served fetch, check idle outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            stalls <= 0;
        end else if (if_re) begin
            if (if_ready) begin
                check("sb_pending", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    check("if_instr", if_instr, sb_q[0].data);
                    check("stall_cycles", stalls, sb_q[0].stalls);
                    void'(sb_q.pop_front());
                end
                stalls <= 0;
            end else begin
                check("stall_instr_zero", if_instr, 0);
                stalls <= stalls + 1;
            end
        end else begin
            check("idle_ready", if_ready, 1);
            check("idle_instr", if_instr, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one fetch and hold it until served. Optionally pulse flush at cycle
    // flush_at (the first access must miss), or switch the address to b at
    // cycle change_at while the first line is being filled.
    task automatic fetch(input logic [15:0] a, input int l, input int flush_at = -1,
                         input logic [15:0] b = 16'h0000, input int change_at = -1);
        exp_t        e;
        logic [15:0] served;
        int          miss_lat;
        int          c;
        bit          done;
        miss_lat = 4 * l + 2;
        served   = a;
        if (m_hit(a)) begin
            e.stalls = 0;
        end else begin
            m_install(a);
            m_misses++;
            e.stalls = miss_lat;
            if (flush_at >= 0) begin
                m_flush();
                m_install(a);
                m_misses++;
                e.stalls = 2 * miss_lat;
            end else if (change_at >= 0) begin
                served = b;
                if (!m_hit(b)) begin
                    m_install(b);
                    m_misses++;
                    e.stalls += miss_lat;
                end
            end
        end
        m_hits++;
        e.data = mem[served];
        lat = l;
        tick();
        sb_q.push_back(e);
        if_addr = a;
        if_re   = 1'b1;
        c    = 0;
        done = 1'b0;
        while (!done) begin
            flush = (c == flush_at);
            if (c == change_at) if_addr = b;
            @(negedge clk);
            if (if_ready) begin
                done = 1'b1;
            end else if (c > 400) begin
                check("fetch_served_in_budget", if_ready, 1);
                if_re = 1'b0;
                sb_q.delete();
                done = 1'b1;
            end else begin
                tick();
                c++;
            end
        end
        flush = 1'b0;
    endtask

    task automatic idle(input int n, input bit do_flush = 1'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            if_re = 1'b0;
            flush = do_flush && (i == 0);
            @(negedge clk);
        end
        if (do_flush) m_flush();
    endtask

    task automatic check_counters();
        idle(1);
        check("hit_cnt", hit_cnt, m_hits);
        check("miss_cnt", miss_cnt, m_misses);
    endtask

    // Watchdog: stop a hung run
    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus sequence
    initial begin
        int          base;
        logic [15:0] addr;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        m_flush();

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("reset_mem_re", mem_re, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_if_ready", if_ready, 1);
        check("reset_hit_cnt", hit_cnt, 0);
        check("reset_miss_cnt", miss_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Cold miss at L=1, then hits on the rest of the line
        fetch(16'h0005, 1);
        fetch(16'h0006, 1);
        fetch(16'h0007, 1);
        check_counters();

        // Conflict on one index: the tag is replaced and the old line misses again
        fetch(16'h0010, 1);
        fetch(16'h0010 + 16'(1 << (INDEX_BITS + 2)), 2);
        fetch(16'h0010, 1);
        fetch(16'h0011, 1);
        check_counters();

        // L=3: address changes mid-fill; the original line still completes
        fetch(16'h1234, 3, -1, 16'h2340, 3);
        fetch(16'h1234, 3);
        fetch(16'h2341, 3);
        fetch(16'h3000, 3);
        check_counters();

        // Flush during FILL installs the line invalid, so the held access misses again
        fetch(16'h0040, 2, 2);
        fetch(16'h0041, 2);
        fetch(16'h0005, 1);
        check_counters();

        // Flush in IDLE invalidates everything
        idle(1, 1'b1);
        fetch(16'h0040, 1);
        fetch(16'h0005, 1);
        check_counters();

        // Reset mid-fill after two words
        lat = 3;
        tick();
        if_addr = 16'h0abc;
        if_re   = 1'b1;
        base    = words_accepted;
        for (int i = 0; i < 100 && words_accepted < base + 2; i++) @(negedge clk);
        check("words_before_reset", words_accepted - base, 2);
        #2 rst_n = 1'b0;
        #1;
        check("midfill_reset_mem_re", mem_re, 0);
        check("midfill_reset_hit_cnt", hit_cnt, 0);
        check("midfill_reset_miss_cnt", miss_cnt, 0);
        check("midfill_reset_ready_busy", if_ready, 0);
        check("midfill_reset_instr", if_instr, 0);
        if_re = 1'b0;
        #1;
        check("midfill_reset_ready_idle", if_ready, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        m_flush();
        m_hits   = 0;
        m_misses = 0;
        sb_q.delete();
        fetch(16'h0abc, 3);
        check_counters();

        // Randomized traffic over a small set of tags/indices to mix hits and conflicts
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle(1, $urandom_range(0, 3) == 0);
            end else begin
                addr = {8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                fetch(addr, $urandom_range(1, 3));
            end
            if (n % 50 == 49) check_counters();
        end
        check_counters();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
